// File: rtl/uart_tx_arbiter_if.sv
// Byte-request and UART transmitter bundle shared between the requesters/transmitter
// (master side) and the round-robin arbiter (slave side).
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   done;
    logic [7:0]        tx_p_data;
    logic              tx_data_valid;
    logic              tx_busy;
    logic              to_err;

    modport master (
        output req, lock, req_data, tx_busy,
        input  gnt, ack, done, tx_p_data, tx_data_valid, to_err
    );

    modport slave (
        input  req, lock, req_data, tx_busy,
        output gnt, ack, done, tx_p_data, tx_data_valid, to_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters,
// with locked bursts and a watchdog for a transmitter that never goes busy.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned   PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned   CW       = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   owner_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] ack_q;
    logic [NREQ-1:0] done_q;
    logic [7:0]      tx_p_data_q;
    logic            tx_data_valid_q;
    logic            to_err_q;

    logic [PW-1:0]   win_c;
    logic            win_found_c;
    logic [PW-1:0]   ptr_next_c;
    logic [7:0]      win_data_c;
    logic [7:0]      own_data_c;
    logic            own_burst_c;
    int unsigned     idx_c;

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win_c       = '0;
        win_found_c = 1'b0;
        idx_c       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx_c = (32'(ptr_q) + i) % NREQ;
            if (!win_found_c && bus.req[PW'(idx_c)]) begin
                win_found_c = 1'b1;
                win_c       = PW'(idx_c);
            end
        end
    end

    assign ptr_next_c  = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
    assign win_data_c  = bus.req_data[{win_c, 3'b000} +: 8];
    assign own_data_c  = bus.req_data[{owner_q, 3'b000} +: 8];
    assign own_burst_c = bus.lock[owner_q] && bus.req[owner_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            owner_q         <= '0;
            cnt_q           <= '0;
            gnt_q           <= '0;
            ack_q           <= '0;
            done_q          <= '0;
            tx_p_data_q     <= '0;
            tx_data_valid_q <= 1'b0;
            to_err_q        <= 1'b0;
        end else begin
            ack_q           <= '0;
            done_q          <= '0;
            tx_data_valid_q <= 1'b0;
            to_err_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found_c && !bus.tx_busy) begin
                        owner_q     <= win_c;
                        gnt_q       <= NREQ'(1) << win_c;
                        tx_p_data_q <= win_data_c;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_data_valid_q <= 1'b1;
                    ack_q           <= gnt_q;
                    cnt_q           <= '0;
                    state_q         <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        // Transmitter never started: drop the byte, no completion.
                        to_err_q <= 1'b1;
                        gnt_q    <= '0;
                        ptr_q    <= ptr_next_c;
                        state_q  <= IDLE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        done_q <= gnt_q;
                        if (own_burst_c) begin
                            tx_p_data_q <= own_data_c;
                            state_q     <= ISSUE;
                        end else begin
                            gnt_q   <= '0;
                            ptr_q   <= ptr_next_c;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.ack           = ack_q;
    assign bus.done          = done_q;
    assign bus.tx_p_data     = tx_p_data_q;
    assign bus.tx_data_valid = tx_data_valid_q;
    assign bus.to_err        = to_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// round-robin traffic checked against a transaction-level arbitration model.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int T    = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(T)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int inv_errs = 0;
    int bound_errs = 0;
    int mptr = 0;
    bit rand_data = 1'b0;
    logic [8*NREQ-1:0] cur_data = '0;
    logic [8*NREQ-1:0] hist1 = '0;
    logic [8*NREQ-1:0] hist2 = '0;

    // Transmitter model: goes busy the edge after a valid strobe, for tx_len cycles.
    int unsigned tx_len = 6;
    bit tx_stuck = 1'b0;
    bit force_busy = 1'b0;
    logic model_busy;
    int unsigned model_cnt;
    always @(posedge clk) begin
        if (!rst_n) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (bus.tx_data_valid && !tx_stuck) begin
            model_busy <= 1'b1;
            model_cnt  <= tx_len - 1;
        end else if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
        end else begin
            model_busy <= 1'b0;
        end
    end
    assign bus.tx_busy = model_busy | force_busy;

    // Protocol invariants, tallied and judged at the end of the run.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!$onehot0(bus.gnt) || !$onehot0(bus.ack) || !$onehot0(bus.done)) inv_errs++;
            if (bus.tx_data_valid && bus.tx_busy) inv_errs++;
            if (bus.tx_data_valid != (bus.ack != '0)) inv_errs++;
            if (bus.ack != '0 && bus.ack != bus.gnt) inv_errs++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(input logic [8*NREQ-1:0] d, input int i);
        return d[8*i +: 8];
    endfunction

    // Advance to the next falling edge; data driven here is what the next rising edge sees.
    task automatic tick();
        @(negedge clk);
        cyc++;
        hist2 = hist1;
        hist1 = cur_data;
        if (rand_data) for (int k = 0; k < NREQ; k++) cur_data[8*k +: 8] = 8'($urandom);
        bus.req_data = cur_data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus.lock = '0;
        tx_stuck = 1'b0;
        force_busy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        mptr = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (bus.gnt == '0 && !bus.tx_busy) return;
            tick();
        end
        bound_errs++;
        $display("FAIL wait_idle: gnt=%b busy=%b still active", bus.gnt, bus.tx_busy);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus.lock = '0;
        bus.req_data = '0;
        tick();
        tick();
        checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
        checks++; if (bus.ack !== '0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
        checks++; if (bus.done !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.tx_data_valid); end
        checks++; if (bus.to_err !== 1'b0) begin errors++; $display("FAIL reset_to_err: got %b want 0", bus.to_err); end
        checks++; if (bus.tx_p_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.tx_p_data); end
        rst_n = 1'b1;
        mptr = 0;
    endtask

    task automatic test_single_byte();
        int vcyc;
        int got;
        bit seen;
        rand_data = 1'b0;
        cur_data = '0;
        cur_data[7:0] = 8'hA5;
        bus.req_data = cur_data;
        tx_len = 20;
        tick();
        bus.req = 4'b0001;
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", bus.gnt); end
        checks++; if (bus.tx_p_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", bus.tx_p_data); end
        checks++; if (bus.tx_data_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", bus.tx_data_valid); end
        tick();
        checks++; if (!(bus.tx_data_valid === 1'b1 && bus.ack === 4'b0001)) begin
            errors++; $display("FAIL single_issue: valid=%b ack=%b want 1/0001", bus.tx_data_valid, bus.ack);
        end
        vcyc = cyc;
        bus.req = '0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (bus.done != '0) seen = 1'b1;
        end
        got = cyc - vcyc;
        checks++; if (!seen || bus.done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", bus.done); end
        checks++; if (got != int'(tx_len) + 2) begin errors++; $display("FAIL single_done_time: got %0d want %0d", got, tx_len + 2); end
        tick();
        checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL single_release: got %b want 0", bus.gnt); end
        mptr = 1;
        // Pointer moved past 0: with 0 and 1 both asking, 1 wins.
        bus.req = 4'b0011;
        tick();
        checks++; if (bus.gnt !== (NREQ'(1) << pick(4'b0011, mptr))) begin
            errors++; $display("FAIL single_ptr: got %b want %b", bus.gnt, NREQ'(1) << pick(4'b0011, mptr));
        end
        bus.req = '0;
        mptr = (pick(4'b0011, mptr) + 1) % NREQ;
        wait_idle();
    endtask

    task automatic test_round_robin();
        int cnt[NREQ];
        int nack = 0;
        int n;
        int e;
        do_reset();
        rand_data = 1'b0;
        cur_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req_data = cur_data;
        foreach (cnt[k]) cnt[k] = 0;
        bus.req = 4'b1111;
        for (int i = 0; i < 300 && nack < 5; i++) begin
            tick();
            if (bus.ack != '0) begin
                n = idx_of(bus.ack);
                e = pick(4'b1111, mptr);
                checks++; if (n != e) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", nack, n, e); end
                checks++; if (bus.tx_p_data !== byte_of(cur_data, e)) begin
                    errors++; $display("FAIL rr_data[%0d]: got %h want %h", nack, bus.tx_p_data, byte_of(cur_data, e));
                end
                if (n >= 0) cnt[n]++;
                mptr = (e + 1) % NREQ;
                nack++;
                tx_len = $urandom_range(2, 5);
                if (nack == 4) begin
                    checks++; if (!(cnt[0] == 1 && cnt[1] == 1 && cnt[2] == 1 && cnt[3] == 1)) begin
                        errors++; $display("FAIL rr_rotation: got %0d%0d%0d%0d want 1111", cnt[0], cnt[1], cnt[2], cnt[3]);
                    end
                end
            end
        end
        bus.req = '0;
        checks++; if (nack != 5) begin errors++; $display("FAIL rr_count: got %0d want 5", nack); end
        wait_idle();
    endtask

    task automatic test_burst();
        int seq[4] = '{0, 0, 0, 2};
        int k = 0;
        int lastdone = -100;
        int n;
        do_reset();
        rand_data = 1'b1;
        tx_len = 4;
        bus.req = 4'b0101;
        bus.lock = 4'b0001;
        for (int i = 0; i < 300 && k < 4; i++) begin
            tick();
            if (bus.ack != '0) begin
                n = idx_of(bus.ack);
                checks++; if (n != seq[k]) begin errors++; $display("FAIL burst_owner[%0d]: got %0d want %0d", k, n, seq[k]); end
                checks++; if (bus.tx_p_data !== byte_of(hist2, seq[k])) begin
                    errors++; $display("FAIL burst_data[%0d]: got %h want %h", k, bus.tx_p_data, byte_of(hist2, seq[k]));
                end
                if (k > 0) begin
                    checks++; if (cyc - lastdone != ((k < 3) ? 1 : 2)) begin
                        errors++; $display("FAIL burst_gap[%0d]: got %0d want %0d", k, cyc - lastdone, (k < 3) ? 1 : 2);
                    end
                end
                if (k == 2) bus.lock = '0;
                k++;
            end
            if (bus.done != '0) lastdone = cyc;
        end
        bus.req = '0;
        checks++; if (k != 4) begin errors++; $display("FAIL burst_count: got %0d want 4", k); end
        wait_idle();
        mptr = 3;
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        int early = 0;
        bit sawdone = 1'b0;
        do_reset();
        rand_data = 1'b0;
        tx_stuck = 1'b1;
        bus.req = 4'b0010;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.ack != '0) seen = 1'b1;
        end
        checks++; if (bus.ack !== 4'b0010) begin errors++; $display("FAIL to_ack: got %b want 0010", bus.ack); end
        bus.req = '0;
        for (int j = 1; j <= T; j++) begin
            tick();
            if (bus.done != '0) sawdone = 1'b1;
            if (j < T && bus.to_err) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL to_early: got %0d early pulses want 0", early); end
        checks++; if (bus.to_err !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", bus.to_err); end
        checks++; if (sawdone) begin errors++; $display("FAIL to_done: got done want none"); end
        checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL to_release: got %b want 0", bus.gnt); end
        mptr = 2;
        tx_stuck = 1'b0;
        bus.req = 4'b0111;
        tick();
        checks++; if (bus.to_err !== 1'b0) begin errors++; $display("FAIL to_width: got %b want 0", bus.to_err); end
        checks++; if (bus.gnt !== (NREQ'(1) << pick(4'b0111, mptr))) begin
            errors++; $display("FAIL to_ptr: got %b want %b", bus.gnt, NREQ'(1) << pick(4'b0111, mptr));
        end
        bus.req = '0;
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        bit busy_seen = 1'b0;
        bit sawdone = 1'b0;
        do_reset();
        rand_data = 1'b1;
        tx_len = 20;
        bus.req = 4'b0001;
        for (int i = 0; i < 10 && !busy_seen; i++) begin
            tick();
            if (bus.tx_busy) busy_seen = 1'b1;
        end
        tick();
        tick();
        bus.req = '0;
        checks++; if (!busy_seen || bus.gnt !== 4'b0001) begin
            errors++; $display("FAIL rmf_setup: busy=%b gnt=%b want 1/0001", busy_seen, bus.gnt);
        end
        rst_n = 1'b0;
        tick();
        checks++; if ({bus.gnt, bus.ack, bus.done, bus.tx_data_valid, bus.to_err, bus.tx_p_data} !== '0) begin
            errors++; $display("FAIL rmf_outputs: gnt=%b ack=%b done=%b valid=%b to=%b data=%h want all 0",
                bus.gnt, bus.ack, bus.done, bus.tx_data_valid, bus.to_err, bus.tx_p_data);
        end
        rst_n = 1'b1;
        mptr = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done != '0) sawdone = 1'b1;
        end
        checks++; if (sawdone) begin errors++; $display("FAIL rmf_done: got done after reset want none"); end
        bus.req = 4'b1000;
        tick();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL rmf_regrant: got %b want 1000", bus.gnt); end
        bus.req = '0;
        wait_idle();
        mptr = 0;
    endtask

    task automatic test_busy_idle();
        int bad = 0;
        do_reset();
        tx_len = 3;
        force_busy = 1'b1;
        bus.req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.gnt != '0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL busy_hold: got %0d granted cycles want 0", bad); end
        force_busy = 1'b0;
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL busy_release_gnt: got %b want 0001", bus.gnt); end
        tick();
        checks++; if (!(bus.ack === 4'b0001 && bus.tx_data_valid === 1'b1)) begin
            errors++; $display("FAIL busy_release_issue: ack=%b valid=%b want 0001/1", bus.ack, bus.tx_data_valid);
        end
        bus.req = '0;
        wait_idle();
        mptr = 1;
    endtask

    task automatic test_random_rr();
        logic [NREQ-1:0] pat;
        int nack;
        int n;
        int e;
        do_reset();
        rand_data = 1'b1;
        for (int ph = 0; ph < 6; ph++) begin
            pat = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            tx_len = $urandom_range(1, 6);
            bus.req = pat;
            nack = 0;
            for (int i = 0; i < 400 && nack < 6; i++) begin
                tick();
                if (bus.ack != '0) begin
                    n = idx_of(bus.ack);
                    e = pick(pat, mptr);
                    checks++; if (n != e) begin errors++; $display("FAIL rand_owner[%0d.%0d]: got %0d want %0d req=%b", ph, nack, n, e, pat); end
                    checks++; if (bus.tx_p_data !== byte_of(hist2, e)) begin
                        errors++; $display("FAIL rand_data[%0d.%0d]: got %h want %h", ph, nack, bus.tx_p_data, byte_of(hist2, e));
                    end
                    mptr = (e + 1) % NREQ;
                    tx_len = $urandom_range(1, 6);
                    nack++;
                end
            end
            bus.req = '0;
            checks++; if (nack != 6) begin errors++; $display("FAIL rand_count[%0d]: got %0d want 6", ph, nack); end
            wait_idle();
        end
    endtask

    task automatic test_invariants();
        checks++; if (inv_errs != 0) begin errors++; $display("FAIL invariants: got %0d violations want 0", inv_errs); end
        checks++; if (bound_errs != 0) begin errors++; $display("FAIL bounded_waits: got %0d expired want 0", bound_errs); end
    endtask

    initial begin
        bus.req = '0;
        bus.lock = '0;
        bus.req_data = '0;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_burst();
        test_timeout();
        test_reset_mid_frame();
        test_busy_idle();
        test_random_rr();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
